// File: rtl/mmio_bridge_n.sv
// mmio_bridge_n: address decode and load/store steering between a core and
// data memory plus N_DEV timer-class device windows, with alignment/access
// exception codes, registered load return with sign/zero extension, and an
// edge-triggered interrupt pending register packed into hw_int.
// Optional build macro: MMIO_BRIDGE_IRQ_SYNC_EN adds a 2-flop synchronizer
// on irq/ext_int ahead of the edge detector.
module mmio_bridge_n #(
  parameter int unsigned N_DEV    = 2,
  parameter logic [31:0] DM_TOP   = 32'h0000_2fff,
  parameter logic [31:0] DEV_BASE = 32'h0000_7f00,
  parameter int unsigned RO_WORD  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [2:0]           sop,
  input  logic [2:0]           lop,
  input  logic                 int_req,
  input  logic                 respond,
  input  logic [31:0]          dm_rdata,
  input  logic [32*N_DEV-1:0]  dev_rdata,
  output logic [31:0]          dm_addr,
  output logic [3:0]           dm_byteen,
  output logic [31:0]          dm_wdata,
  output logic [N_DEV-1:0]     dev_we,
  output logic [31:0]          dev_wdata,
  output logic [31:0]          rdata,
  output logic                 rd_valid,
  output logic [4:0]           exc_code,
  input  logic [N_DEV-1:0]     irq,
  input  logic                 ext_int,
  input  logic [N_DEV:0]       irq_ack,
  output logic [5:0]           hw_int
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] ST_SW   = 3'd1;
  localparam logic [2:0] ST_SH   = 3'd2;
  localparam logic [2:0] ST_SB   = 3'd3;
  localparam logic [2:0] LD_LW   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LHU  = 3'd3;
  localparam logic [2:0] LD_LB   = 3'd4;
  localparam logic [2:0] LD_LBU  = 3'd5;

  logic             dm_hit_s;
  logic [N_DEV-1:0] win_hit_s;
  logic [1:0]       win_idx_s;
  logic             any_win_s;
  logic             ld_bad_s;
  logic             st_bad_s;
  logic             ld_go_s;
  logic             rd_valid_r;
  logic             src_dm_r;
  logic [1:0]       src_idx_r;
  logic [1:0]       off_r;
  logic [2:0]       lop_r;
  logic [31:0]      word_s;
  logic [31:0]      byte_sh_s;
  logic [31:0]      half_sh_s;
  logic [N_DEV:0]   lines_s;
  logic [N_DEV:0]   edge_src_s;
  logic [N_DEV:0]   line_d_r;
  logic [N_DEV:0]   pend_r;

  // Address decode: data memory range and one hit bit per device window.
  always_comb begin
    dm_hit_s  = (addr <= DM_TOP);
    win_hit_s = {N_DEV{1'b0}};
    win_idx_s = 2'd0;
    for (int i = 0; i < N_DEV; i++) begin
      win_hit_s[i] = (addr >= (DEV_BASE + 32'(16 * i))) &&
                     (addr <= (DEV_BASE + 32'(16 * i + 11)));
      win_idx_s    = win_hit_s[i] ? 2'(i) : win_idx_s;
    end
    any_win_s = |win_hit_s;
  end

  // Access-fault classification; load faults take priority over store faults.
  always_comb begin
    ld_bad_s = 1'b0;
    st_bad_s = 1'b0;
    if (lop != OP_NONE) begin
      ld_bad_s = (!dm_hit_s && !any_win_s) ||
                 (any_win_s && (lop != LD_LW)) ||
                 ((lop == LD_LW) && (addr[1:0] != 2'b00)) ||
                 (((lop == LD_LH) || (lop == LD_LHU)) && addr[0]);
    end else begin
      ld_bad_s = 1'b0;
    end
    if (sop != OP_NONE) begin
      st_bad_s = (!dm_hit_s && !any_win_s) ||
                 (any_win_s && (sop != ST_SW)) ||
                 ((sop == ST_SW) && (addr[1:0] != 2'b00)) ||
                 ((sop == ST_SH) && addr[0]) ||
                 (any_win_s && (addr[3:2] == 2'(RO_WORD)));
    end else begin
      st_bad_s = 1'b0;
    end
    if (ld_bad_s) begin
      exc_code = 5'd4;
    end else if (st_bad_s) begin
      exc_code = 5'd5;
    end else begin
      exc_code = 5'd0;
    end
    ld_go_s = (lop != OP_NONE) && !ld_bad_s && !st_bad_s;
  end

  // Store steering: memory byte lanes, replicated write data, device write enables.
  always_comb begin
    dm_addr   = respond ? 32'h0000_7f20 : addr;
    dm_byteen = 4'h0;
    dev_wdata = wdata;
    case (sop)
      ST_SH:   dm_wdata = {2{wdata[15:0]}};
      ST_SB:   dm_wdata = {4{wdata[7:0]}};
      default: dm_wdata = wdata;
    endcase
    if (!reset_n) begin
      dm_byteen = 4'h0;
    end else if (respond) begin
      dm_byteen = 4'hf;
    end else if (int_req || (exc_code != 5'd0) || !dm_hit_s) begin
      dm_byteen = 4'h0;
    end else begin
      case (sop)
        ST_SW:   dm_byteen = 4'hf;
        ST_SH:   dm_byteen = addr[1] ? 4'b1100 : 4'b0011;
        ST_SB:   dm_byteen = 4'b0001 << addr[1:0];
        default: dm_byteen = 4'h0;
      endcase
    end
    dev_we = {N_DEV{1'b0}};
    for (int i = 0; i < N_DEV; i++) begin
      dev_we[i] = reset_n && (sop == ST_SW) && win_hit_s[i] && !int_req &&
                  (exc_code == 5'd0);
    end
  end

  // Load capture: remember source, byte offset and op for next-cycle return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_r <= 1'b0;
      src_dm_r   <= 1'b0;
      src_idx_r  <= 2'd0;
      off_r      <= 2'd0;
      lop_r      <= 3'd0;
    end else begin
      rd_valid_r <= ld_go_s;
      if (ld_go_s) begin
        src_dm_r  <= dm_hit_s;
        src_idx_r <= win_idx_s;
        off_r     <= addr[1:0];
        lop_r     <= lop;
      end else begin
        src_dm_r  <= src_dm_r;
        src_idx_r <= src_idx_r;
        off_r     <= off_r;
        lop_r     <= lop_r;
      end
    end
  end

  // Load return: pick the live source word and extend per the captured op.
  always_comb begin
    word_s = dm_rdata;
    if (!src_dm_r) begin
      for (int i = 0; i < N_DEV; i++) begin
        word_s = (src_idx_r == 2'(i)) ? dev_rdata[32*i +: 32] : word_s;
      end
    end else begin
      word_s = dm_rdata;
    end
    byte_sh_s = word_s >> {off_r, 3'b000};
    half_sh_s = word_s >> {off_r[1], 4'b0000};
    rdata     = 32'h0;
    if (rd_valid_r) begin
      case (lop_r)
        LD_LH:   rdata = {{16{half_sh_s[15]}}, half_sh_s[15:0]};
        LD_LHU:  rdata = {16'h0, half_sh_s[15:0]};
        LD_LB:   rdata = {{24{byte_sh_s[7]}}, byte_sh_s[7:0]};
        LD_LBU:  rdata = {24'h0, byte_sh_s[7:0]};
        default: rdata = word_s;
      endcase
    end else begin
      rdata = 32'h0;
    end
    rd_valid = rd_valid_r;
  end

  assign lines_s = {ext_int, irq};

`ifdef MMIO_BRIDGE_IRQ_SYNC_EN
  logic [N_DEV:0] sync1_r;
  logic [N_DEV:0] sync2_r;

  // Two-stage synchronizer for asynchronous interrupt lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= {(N_DEV+1){1'b0}};
      sync2_r <= {(N_DEV+1){1'b0}};
    end else begin
      sync1_r <= lines_s;
      sync2_r <= sync1_r;
    end
  end

  assign edge_src_s = sync2_r;
`else
  assign edge_src_s = lines_s;
`endif

  // Rising-edge detect and pending latch; a new edge beats a same-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_d_r <= {(N_DEV+1){1'b0}};
      pend_r   <= {(N_DEV+1){1'b0}};
    end else begin
      line_d_r <= edge_src_s;
      pend_r   <= (pend_r & ~irq_ack) | (edge_src_s & ~line_d_r);
    end
  end

  // Pack pending bits from bit 0 of the 6-bit interrupt vector.
  always_comb begin
    hw_int          = 6'b000000;
    hw_int[N_DEV:0] = pend_r;
  end

endmodule

// File: tb/tb_mmio_bridge_n.sv
// Self-checking bench for mmio_bridge_n: directed scenarios followed by
// random traffic, all compared against a rule-level reference model.
module tb_mmio_bridge_n;

  localparam int unsigned N_DEV    = 2;
  localparam logic [31:0] DM_TOP   = 32'h0000_2fff;
  localparam logic [31:0] DEV_BASE = 32'h0000_7f00;
  localparam int unsigned RO_WORD  = 2;
`ifdef MMIO_BRIDGE_IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam logic [2:0] SW = 3'd1, SH = 3'd2, SB = 3'd3;
  localparam logic [2:0] LW = 3'd1, LH = 3'd2, LHU = 3'd3, LB = 3'd4, LBU = 3'd5;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [31:0]         addr, wdata, dm_rdata;
  logic [2:0]          sop, lop;
  logic                int_req, respond, ext_int;
  logic [32*N_DEV-1:0] dev_rdata;
  logic [N_DEV-1:0]    irq;
  logic [N_DEV:0]      irq_ack;
  logic [31:0]         dm_addr, dm_wdata, dev_wdata, rdata;
  logic [3:0]          dm_byteen;
  logic [N_DEV-1:0]    dev_we;
  logic                rd_valid;
  logic [4:0]          exc_code;
  logic [5:0]          hw_int;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic           exp_valid;
  int             exp_src;
  logic [1:0]     exp_off;
  logic [2:0]     exp_lop;
  logic [N_DEV:0] pend_m;
  logic [N_DEV:0] hist [0:4095];
  int             cyc_m;

  mmio_bridge_n #(.N_DEV(N_DEV), .DM_TOP(DM_TOP), .DEV_BASE(DEV_BASE), .RO_WORD(RO_WORD)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .sop(sop), .lop(lop),
    .int_req(int_req), .respond(respond), .dm_rdata(dm_rdata), .dev_rdata(dev_rdata),
    .dm_addr(dm_addr), .dm_byteen(dm_byteen), .dm_wdata(dm_wdata), .dev_we(dev_we),
    .dev_wdata(dev_wdata), .rdata(rdata), .rd_valid(rd_valid), .exc_code(exc_code),
    .irq(irq), .ext_int(ext_int), .irq_ack(irq_ack), .hw_int(hw_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // -1 = data memory, 0..N_DEV-1 = device window, -2 = unmapped
  function automatic int region(input logic [31:0] a);
    if (a <= DM_TOP) return -1;
    for (int i = 0; i < N_DEV; i++) begin
      if (a >= DEV_BASE + 32'(16 * i) && a < DEV_BASE + 32'(16 * i + 12)) return i;
    end
    return -2;
  endfunction

  function automatic logic [4:0] exc_model(input logic [31:0] a, input logic [2:0] l, input logic [2:0] s);
    int r;
    int widx;
    r = region(a);
    widx = (r >= 0) ? int'((a - DEV_BASE - 32'(16 * r)) / 4) : -1;
    if (l != 3'd0) begin
      if (r == -2) return 5'd4;
      if (r >= 0 && l != LW) return 5'd4;
      if (l == LW && (a % 4) != 0) return 5'd4;
      if ((l == LH || l == LHU) && (a % 2) != 0) return 5'd4;
    end
    if (s != 3'd0) begin
      if (r == -2) return 5'd5;
      if (r >= 0 && s != SW) return 5'd5;
      if (s == SW && (a % 4) != 0) return 5'd5;
      if (s == SH && (a % 2) != 0) return 5'd5;
      if (r >= 0 && widx == int'(RO_WORD)) return 5'd5;
    end
    return 5'd0;
  endfunction

  function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] l, input logic [1:0] off);
    logic [31:0] v;
    case (l)
      LH, LHU: begin
        v = (w >> (16 * (int'(off) / 2))) & 32'h0000_ffff;
        if (l == LH && v >= 32'h8000) v = v + 32'hffff_0000;
      end
      LB, LBU: begin
        v = (w >> (8 * int'(off))) & 32'h0000_00ff;
        if (l == LB && v >= 32'h80) v = v + 32'hffff_ff00;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [N_DEV:0] hist_at(input int c);
    if (c < 0) return '0;
    return hist[c];
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_src   = -1;
    exp_off   = 2'd0;
    exp_lop   = 3'd0;
    pend_m    = '0;
    cyc_m     = 0;
  endtask

  // One cycle: check outputs against the model, then advance the model over the edge.
  task automatic step();
    int             r;
    logic [4:0]     e;
    logic [N_DEV-1:0] we_e;
    logic [3:0]     be_e;
    logic [31:0]    w;
    logic [N_DEV:0] src, prv;
    #1;
    r = region(addr);
    e = exc_model(addr, lop, sop);
    chk("exc_code", 32'(exc_code), 32'(e));
    we_e = '0;
    if (sop == SW && r >= 0 && !int_req && e == 5'd0) we_e[r] = 1'b1;
    chk("dev_we", 32'(dev_we), 32'(we_e));
    if (respond) be_e = 4'hf;
    else if (int_req || e != 5'd0 || r != -1) be_e = 4'h0;
    else if (sop == SW) be_e = 4'hf;
    else if (sop == SH) be_e = addr[1] ? 4'hc : 4'h3;
    else if (sop == SB) be_e = 4'(1 << addr[1:0]);
    else be_e = 4'h0;
    chk("dm_byteen", 32'(dm_byteen), 32'(be_e));
    chk("dm_addr", dm_addr, respond ? 32'h7f20 : addr);
    chk("dev_wdata", dev_wdata, wdata);
    if (sop == SW) chk("dm_wdata", dm_wdata, wdata);
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (exp_valid) begin
      w = (exp_src < 0) ? dm_rdata : dev_rdata[32*exp_src +: 32];
      chk("rdata", rdata, ext_model(w, exp_lop, exp_off));
    end
    chk("hw_int", 32'(hw_int), 32'(pend_m));
    @(posedge clk);
    exp_valid = (lop != 3'd0) && (e == 5'd0);
    exp_src   = r;
    exp_off   = addr[1:0];
    exp_lop   = lop;
    if (cyc_m < 4096) hist[cyc_m] = {ext_int, irq};
    src    = hist_at(cyc_m - LAT);
    prv    = hist_at(cyc_m - LAT - 1);
    pend_m = (pend_m & ~irq_ack) | (src & ~prv);
    cyc_m++;
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0:       addr = 32'($urandom_range(0, 32'h2fff));
      1:       addr = 32'h2ffc + 32'($urandom_range(0, 7));
      2, 3:    addr = DEV_BASE + 32'(16 * $urandom_range(0, N_DEV - 1)) + 32'($urandom_range(0, 15));
      4:       addr = 32'h3000 + 32'($urandom_range(0, 32'h4eff));
      default: addr = $urandom;
    endcase
    if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
    lop = 3'd0;
    sop = 3'd0;
    k = $urandom_range(0, 3);
    if (k == 1 || k == 2) lop = 3'($urandom_range(1, 5));
    else if (k == 3) sop = 3'($urandom_range(1, 3));
    int_req   = ($urandom_range(0, 5) == 0);
    respond   = ($urandom_range(0, 7) == 0);
    wdata     = $urandom;
    dm_rdata  = $urandom;
    dev_rdata = {$urandom, $urandom};
    for (int i = 0; i < N_DEV; i++) if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
    if ($urandom_range(0, 7) == 0) ext_int = ~ext_int;
    for (int i = 0; i <= N_DEV; i++) irq_ack[i] = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    reset_n = 1'b0; addr = 32'h10; wdata = 32'h0; sop = SW; lop = 3'd0;
    int_req = 1'b0; respond = 1'b1; dm_rdata = 32'h0; dev_rdata = '0;
    irq = '0; ext_int = 1'b0; irq_ack = '0;
    model_reset();
    #2;
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_hw_int", 32'(hw_int), 32'h0);
    chk("rst_byteen", 32'(dm_byteen), 32'h0);
    addr = 32'h7f04; respond = 1'b0;
    #1 chk("rst_dev_we", 32'(dev_we), 32'h0);
    @(negedge clk); @(negedge clk);
    sop = 3'd0; addr = 32'h0;
    reset_n = 1'b1;
    model_reset();

    // LW from data memory
    addr = 32'h10; lop = LW; dm_rdata = 32'h8000_00ff; step();
    lop = 3'd0; #1;
    chk("lw_valid", 32'(rd_valid), 32'h1);
    chk("lw_rdata", rdata, 32'h8000_00ff);
    step();

    // back-to-back LB then LBU at byte 3
    addr = 32'h13; lop = LB; step();
    lop = LBU; dm_rdata = 32'h80a5_c3e1; #1;
    chk("lb_rdata", rdata, 32'hffff_ff80);
    step();
    lop = 3'd0; #1;
    chk("lbu_valid", 32'(rd_valid), 32'h1);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    step();

    // device window store, then blocked by int_req
    addr = 32'h7f14; sop = SW; wdata = 32'hdead_beef; #1;
    chk("sw_win1_we", 32'(dev_we), 32'h2);
    step();
    int_req = 1'b1; #1;
    chk("sw_intreq_we", 32'(dev_we), 32'h0);
    chk("sw_intreq_exc", 32'(exc_code), 32'h0);
    step();
    int_req = 1'b0;

    // faults and boundaries
    addr = 32'h7f08; #1;
    chk("sw_ro_exc", 32'(exc_code), 32'h5);
    chk("sw_ro_we", 32'(dev_we), 32'h0);
    step();
    sop = 3'd0; addr = 32'h7f00; lop = LH; #1;
    chk("lh_win_exc", 32'(exc_code), 32'h4);
    step();
    lop = 3'd0; #1 chk("lh_win_novalid", 32'(rd_valid), 32'h0);
    step();
    addr = 32'h3000; lop = LW; #1 chk("lw_oor_exc", 32'(exc_code), 32'h4);
    step();
    addr = 32'h2ffc; #1 chk("lw_dmtop_exc", 32'(exc_code), 32'h0);
    step();
    addr = 32'h2fff; lop = LB; #1 chk("lb_dmtop_exc", 32'(exc_code), 32'h0);
    step();
    addr = 32'h7f0c; lop = LW; #1 chk("lw_win_gap_exc", 32'(exc_code), 32'h4);
    step();
    addr = 32'h7f18; lop = LW; dev_rdata = {32'h0123_4567, 32'h89ab_cdef}; step();
    lop = 3'd0; #1 chk("lw_win1_rdata", rdata, 32'h0123_4567);
    step();
    addr = 32'h7f0b; sop = SB; #1 chk("sb_win_exc", 32'(exc_code), 32'h5);
    step();
    sop = 3'd0;

    // interrupt pending behaviour
    irq_ack = '1; for (int i = 0; i < LAT + 2; i++) step();
    irq_ack = '0;
    irq[0] = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      #1 chk("irq_before_set", 32'(hw_int[0]), 32'h0);
      step();
    end
    #1 chk("irq_set", 32'(hw_int[0]), 32'h1);
    for (int i = 0; i < 3; i++) step();
    #1 chk("irq_held", 32'(hw_int), 32'h1);
    irq_ack[0] = 1'b1; step();
    irq_ack[0] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #1 chk("irq_acked", 32'(hw_int[0]), 32'h0);
    irq[0] = 1'b0; for (int i = 0; i <= LAT; i++) step();
    irq[0] = 1'b1; for (int i = 0; i <= LAT; i++) step();
    #1 chk("irq_reset2", 32'(hw_int[0]), 32'h1);
    irq[0] = 1'b0; for (int i = 0; i <= LAT; i++) step();
    irq[0] = 1'b1; for (int i = 0; i < LAT; i++) step();
    irq_ack[0] = 1'b1; step();
    irq_ack[0] = 1'b0;
    #1 chk("ack_vs_set", 32'(hw_int[0]), 32'h1);
    irq_ack[0] = 1'b1; step();
    irq_ack[0] = 1'b0;
    #1 chk("ack_clear", 32'(hw_int[0]), 32'h0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      randomize_inputs();
      step();
    end

    // reset during an in-flight load with all interrupts pending
    sop = 3'd0; lop = 3'd0; respond = 1'b0; int_req = 1'b0;
    irq = '0; ext_int = 1'b0; irq_ack = '1;
    for (int i = 0; i < LAT + 2; i++) step();
    irq_ack = '0; irq = '1; ext_int = 1'b1;
    for (int i = 0; i < LAT + 2; i++) step();
    #1 chk("pend_all", 32'(hw_int), 32'h7);
    addr = 32'h20; lop = LW; step();
    lop = 3'd0; #1 chk("inflight_valid", 32'(rd_valid), 32'h1);
    reset_n = 1'b0; sop = SW; #1;
    chk("arst_rd_valid", 32'(rd_valid), 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    chk("arst_hw_int", 32'(hw_int), 32'h0);
    chk("arst_byteen", 32'(dm_byteen), 32'h0);
    @(posedge clk); @(negedge clk);
    sop = 3'd0; reset_n = 1'b1;
    model_reset();
    step();
    #1 chk("post_rst_novalid", 32'(rd_valid), 32'h0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_bridge_n.md
MMIO_BRIDGE_N -- requirements
Module: mmio_bridge_n

Interface
REQ-001 Parameter N_DEV, default 2, number of timer-class device windows (1..4).
REQ-002 Parameter DM_TOP, default 32'h2fff, highest data-memory byte address.
REQ-003 Parameter DEV_BASE, default 32'h7f00; window i spans DEV_BASE+16*i .. +11.
REQ-004 Parameter RO_WORD, default 2, word index (addr[3:2]) that is read-only in every window.
REQ-005 clk  in  1  the single clock; reset_n  in  1  asynchronous, active-low reset.
REQ-006 addr  in  32  byte address; wdata  in  32  store data.
REQ-007 sop  in  3  store op; lop  in  3  load op. Encodings follow the shared macro header; 0 = none.
REQ-008 int_req  in  1  exception/interrupt in progress; respond  in  1  interrupt-acknowledge write.
REQ-009 dm_rdata  in  32; dev_rdata  in  32*N_DEV  (window i at bits 32i+31:32i).
REQ-010 dm_addr  out  32; dm_byteen  out  4; dm_wdata  out  32.
REQ-011 dev_we  out  N_DEV  one-hot write enable; dev_wdata  out  32.
REQ-012 rdata  out  32  extended load result; rd_valid  out  1.
REQ-013 exc_code  out  5  (0 none, 4 AdEL, 5 AdES).
REQ-014 irq  in  N_DEV; ext_int  in  1; irq_ack  in  N_DEV+1  clear pending; hw_int  out  6.

Function
REQ-015 Decode: DM hit = addr<=DM_TOP; window i hit = addr within window i; out of range = no hit.
REQ-016 exc_code is combinational, priority: AdEL (load out of range; non-LW load to window; LW misaligned; LH/LHU odd) then AdES (same rules for stores; SW to word RO_WORD of a window).
REQ-017 dm_byteen: respond -> 4'hf with dm_addr=32'h7f20; else int_req or exc_code!=0 -> 0; else byte lanes from sop and addr[1:0].
REQ-018 dev_we[i] asserted only for SW hitting window i with int_req=0 and exc_code=0.
REQ-019 Loads are registered: lop!=0 and exc_code=0 at edge k -> rd_valid=1 and rdata valid in cycle k+1, rd_valid low otherwise.
REQ-020 At the load edge the bridge latches source (DM/window i), addr[1:0] and lop; rdata is selected and sign/zero-extended from the latched values and the current data inputs in cycle k+1.
REQ-021 Back-to-back loads each produce one rd_valid cycle; no bubble required.
REQ-022 Pending register pend[N_DEV:0]: bit i set on rising edge of irq[i], bit N_DEV on rising edge of ext_int; edge detector uses a registered copy of each line.
REQ-023 irq_ack[j]=1 clears pend[j]; set and clear in the same cycle -> set wins.
REQ-024 hw_int = {zero pad, pend[N_DEV], pend[N_DEV-1:0]} packed from bit 0; unused bits 0.
REQ-025 A load issued while int_req=1 still returns data; int_req only blocks writes.

Reset
REQ-026 reset_n low asynchronously clears rd_valid, rdata, latched load state, pend and edge-detect registers to 0.
REQ-027 A load in flight when reset asserts is discarded; first edge after release produces no rd_valid.
REQ-028 Combinational outputs depend only on inputs during reset; dev_we and dm_byteen forced 0 while reset_n=0.

Configuration
REQ-029 Macro MMIO_BRIDGE_IRQ_SYNC_EN defined: irq and ext_int pass through a 2-flop synchronizer (reset to 0) before edge detect, adding 2 cycles of pend latency.
REQ-030 Undefined: edge detect samples irq/ext_int directly; pend sets one edge after the rising input.

Verification
REQ-031 LW addr=32'h0000_0010, dm_rdata=32'h8000_00ff -> next cycle rd_valid=1, rdata=32'h8000_00ff.
REQ-032 LB addr=32'h13, dm_rdata=32'h80xx_xxxx -> rdata=32'hffff_ff80; LBU same -> 32'h0000_0080.
REQ-033 SW addr=32'h7f14, N_DEV=2 -> dev_we=2'b10; same with int_req=1 -> dev_we=0, exc_code=0.
REQ-034 SW addr=32'h7f08 -> exc_code=5, dev_we=0; LH addr=32'h7f00 -> exc_code=4, no rd_valid; LW addr=32'h3000 -> exc_code=4.
REQ-035 irq[0] rises, held high -> pend[0]=1 once (1 or 3 cycles per macro), hw_int[0]=1 until irq_ack[0]; ack and new edge same cycle -> stays 1.
REQ-036 Reset pulse during pending load and pend=all-ones -> rd_valid=0, hw_int=0 immediately, no rd_valid after release.
